// File: rtl/deser_pkg.sv
// Shared types and sizing helpers for the serial-in/parallel-out receiver.
package deser_pkg;

    typedef enum logic [0:0] {
        HUNT  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hD5;

    // Bits needed to count from 0 up to and including max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/deser_out_reg.sv
// Single-entry valid/ready holding register for assembled words.
module deser_out_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] word_i,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  full_o
);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;

    // Full means a word is held and will not be taken on this edge.
    assign full_o  = valid_q & ~ready_i;
    assign data_o  = data_q;
    assign valid_o = valid_q;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load_i && !full_o) begin
            data_d  = word_i;
            valid_d = 1'b1;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/deserializer_sipo.sv
// Receive-side deserializer: hunts for an LSB-first sync word, then assembles
// FRAME_WORDS payload words and presents them on a valid/ready interface.
module deserializer_sipo
    import deser_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    SYNC_WIDTH  = 8,
    parameter logic [SYNC_WIDTH-1:0] SYNC_WORD   = SYNC_WIDTH'(DEFAULT_SYNC_WORD),
    parameter int                    FRAME_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  srl_in,
    input  logic                  srl_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  locked,
    output logic                  frame_done,
    output logic                  overrun
);

    localparam int BW = cnt_width(DATA_WIDTH);
    localparam int WW = cnt_width(FRAME_WORDS);
    localparam int HW = cnt_width(SYNC_WIDTH);

    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
    localparam logic [WW-1:0] WORD_LAST = WW'(FRAME_WORDS - 1);
    localparam logic [HW-1:0] HUNT_FULL = HW'(SYNC_WIDTH);

    state_e                  state_q, state_d;
    logic [SYNC_WIDTH-1:0]   sync_sr_q, sync_sr_d, sync_shift;
    logic [HW-1:0]           hunt_cnt_q, hunt_cnt_d, hunt_inc;
    logic [DATA_WIDTH-1:0]   data_sr_q, data_sr_d, data_shift;
    logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [WW-1:0]           word_cnt_q, word_cnt_d;
    logic                    frame_done_q, frame_done_d;
    logic                    overrun_q, overrun_d;
    logic                    sync_match, word_done, frame_end, out_full;

    assign sync_shift = {srl_in, sync_sr_q[SYNC_WIDTH-1:1]};
    assign hunt_inc   = (hunt_cnt_q == HUNT_FULL) ? HUNT_FULL : hunt_cnt_q + 1'b1;
    assign data_shift = {srl_in, data_sr_q[DATA_WIDTH-1:1]};

    // A match needs a full window of bits seen since the last frame ended.
    assign sync_match = (state_q == HUNT) && srl_valid &&
                        (sync_shift == SYNC_WORD) && (hunt_inc == HUNT_FULL);
    assign word_done  = (state_q == SHIFT) && srl_valid && (bit_cnt_q == BIT_LAST);
    assign frame_end  = word_done && (word_cnt_q == WORD_LAST);

    always_comb begin
        state_d      = state_q;
        sync_sr_d    = sync_sr_q;
        hunt_cnt_d   = hunt_cnt_q;
        data_sr_d    = data_sr_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q | (word_done & out_full);
        if (srl_valid) begin
            case (state_q)
                HUNT: begin
                    if (sync_match) begin
                        state_d    = SHIFT;
                        bit_cnt_d  = '0;
                        word_cnt_d = '0;
                        sync_sr_d  = '0;
                        hunt_cnt_d = '0;
                    end else begin
                        sync_sr_d  = sync_shift;
                        hunt_cnt_d = hunt_inc;
                    end
                end
                SHIFT: begin
                    data_sr_d = data_shift;
                    if (word_done) begin
                        bit_cnt_d  = '0;
                        word_cnt_d = word_cnt_q + 1'b1;
                        if (frame_end) begin
                            state_d      = HUNT;
                            word_cnt_d   = '0;
                            frame_done_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HUNT;
            sync_sr_q    <= '0;
            hunt_cnt_q   <= '0;
            data_sr_q    <= '0;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_sr_q    <= sync_sr_d;
            hunt_cnt_q   <= hunt_cnt_d;
            data_sr_q    <= data_sr_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    // The completed word includes the bit sampled on this edge.
    deser_out_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (word_done),
        .word_i  (data_shift),
        .ready_i (data_ready),
        .data_o  (data_out),
        .valid_o (data_valid),
        .full_o  (out_full)
    );

    assign locked     = (state_q == SHIFT);
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_deserializer_sipo.sv
// Self-checking bench: bit streams are decoded by an index-scanning reference
// model and compared with the words handed out on the valid/ready port.
module tb_deserializer_sipo;

    logic       clk = 1'b0;
    logic       rst;
    logic       srl_in;
    logic       srl_valid;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       locked;
    logic       frame_done;
    logic       overrun;

    int errors = 0;
    int checks = 0;

    bit         stream_q[$];
    logic [7:0] exp_q[$];
    int         exp_frames;
    logic [7:0] got_q[$];
    int         fd_cnt = 0;
    int         lock_rises = 0;
    logic       locked_prev = 1'b0;

    always #5 clk = ~clk;

    deserializer_sipo dut (
        .clk        (clk),
        .rst        (rst),
        .srl_in     (srl_in),
        .srl_valid  (srl_valid),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .locked     (locked),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    // Observe on the falling edge: a word counts as delivered when valid&ready
    // are presented to the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            got_q.delete();
            fd_cnt      = 0;
            lock_rises  = 0;
            locked_prev = 1'b0;
        end else begin
            if (data_valid && data_ready) begin
                got_q.push_back(data_out);
                $display("  word delivered: 0x%02h", data_out);
            end
            if (frame_done) fd_cnt++;
            if (locked && !locked_prev) lock_rises++;
            locked_prev = locked;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic drive_bit(input bit b, input bit v);
        @(posedge clk);
        #1;
        srl_in    = b;
        srl_valid = v;
    endtask

    task automatic idle(input int n);
        repeat (n) drive_bit(1'($urandom), 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        srl_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) stream_q.push_back(b[i]);
    endtask

    // Reference: slide an 8-bit window over the valid bits; a window equal to
    // 0xD5 is a sync, the next 32 bits are four words, and the next window
    // may start only after those 32 bits.
    task automatic model_stream();
        int         n;
        int         p;
        logic [7:0] v;
        n = stream_q.size();
        p = 0;
        exp_q.delete();
        exp_frames = 0;
        while (p + 8 <= n) begin
            v = '0;
            for (int j = 0; j < 8; j++) v[j] = stream_q[p + j];
            if (v == 8'hD5) begin
                for (int k = 0; k < 4; k++) begin
                    if (p + 8 + 8 * k + 8 <= n) begin
                        v = '0;
                        for (int j = 0; j < 8; j++) v[j] = stream_q[p + 8 + 8 * k + j];
                        exp_q.push_back(v);
                    end
                end
                if (p + 8 + 32 <= n) exp_frames++;
                p = p + 8 + 32;
            end else begin
                p++;
            end
        end
    endtask

    // gap < 0 selects a random 0..2 idle cycles after each valid bit.
    task automatic send_stream(input int gap);
        int g;
        foreach (stream_q[i]) begin
            drive_bit(stream_q[i], 1'b1);
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            idle(g);
        end
        idle(4);
    endtask

    task automatic test_reset();
        logic [7:0] w;
        $display("test_reset");
        do_reset();
        checks++;
        if (data_valid !== 1'b0 || locked !== 1'b0 || frame_done !== 1'b0 ||
            overrun !== 1'b0 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_state got dv=%b lk=%b fd=%b ov=%b do=%h required all 0",
                     data_valid, locked, frame_done, overrun, data_out);
        end
        data_ready = 1'b0;
        stream_q.delete();
        push_byte(8'hD5);
        for (int i = 0; i < 3; i++) begin
            w = 8'($urandom);
            push_byte(w);
        end
        for (int i = 0; i < 8 + 16 + 3; i++) drive_bit(stream_q[i], 1'b1);
        idle(2);
        checks++;
        if (overrun !== 1'b1 || locked !== 1'b1) begin
            errors++;
            $display("FAIL reset_precond got ov=%b lk=%b required ov=1 lk=1", overrun, locked);
        end
        do_reset();
        idle(1);
        checks++;
        if (data_valid !== 1'b0 || locked !== 1'b0 || frame_done !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_midactivity got dv=%b lk=%b fd=%b ov=%b required all 0",
                     data_valid, locked, frame_done, overrun);
        end
        data_ready = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] gv;
        $display("test_basic");
        do_reset();
        data_ready = 1'b1;
        stream_q.delete();
        push_byte(8'hD5); push_byte(8'h3C); push_byte(8'hA5); push_byte(8'h00); push_byte(8'hFF);
        model_stream();
        for (int i = 0; i < stream_q.size(); i++) begin
            drive_bit(stream_q[i], 1'b1);
            if (i == 7) begin
                checks++;
                if (locked !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_lock_early got=%b required=0", locked);
                end
            end
            if (i == 8) begin
                checks++;
                if (locked !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_lock_rise got=%b required=1", locked);
                end
            end
            if (i == 15) begin
                checks++;
                if (data_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_valid_early got=%b required=0", data_valid);
                end
            end
            if (i == 16) begin
                checks++;
                if (data_valid !== 1'b1 || data_out !== 8'h3C) begin
                    errors++;
                    $display("FAIL basic_latency got dv=%b do=%h required dv=1 do=3c", data_valid, data_out);
                end
            end
        end
        idle(4);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL basic_count got=%0d required=%0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) begin
            gv = (k < got_q.size()) ? got_q[k] : 8'hxx;
            checks++;
            if (gv !== exp_q[k]) begin
                errors++;
                $display("FAIL basic_word%0d got=%h required=%h", k, gv, exp_q[k]);
            end
        end
        checks++;
        if (fd_cnt !== exp_frames || lock_rises !== 1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL basic_frame got fd=%0d rises=%0d lk=%b required fd=%0d rises=1 lk=0",
                     fd_cnt, lock_rises, locked, exp_frames);
        end
    endtask

    task automatic test_false_sync();
        logic [7:0] gv;
        $display("test_false_sync");
        do_reset();
        data_ready = 1'b1;
        stream_q.delete();
        stream_q.push_back(1'b1); stream_q.push_back(1'b0); stream_q.push_back(1'b1);
        push_byte(8'hD5); push_byte(8'hD5);
        for (int i = 0; i < 3; i++) push_byte(8'($urandom));
        model_stream();
        send_stream(0);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL false_sync_count got=%0d required=%0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) begin
            gv = (k < got_q.size()) ? got_q[k] : 8'hxx;
            checks++;
            if (gv !== exp_q[k]) begin
                errors++;
                $display("FAIL false_sync_word%0d got=%h required=%h", k, gv, exp_q[k]);
            end
        end
        checks++;
        if (lock_rises !== 1 || fd_cnt !== 1) begin
            errors++;
            $display("FAIL false_sync_lock got rises=%0d fd=%0d required rises=1 fd=1", lock_rises, fd_cnt);
        end
    endtask

    task automatic test_backpressure();
        $display("test_backpressure");
        do_reset();
        data_ready = 1'b0;
        stream_q.delete();
        push_byte(8'hD5); push_byte(8'h3C); push_byte(8'hA5); push_byte(8'h00); push_byte(8'hFF);
        model_stream();
        for (int i = 0; i < stream_q.size(); i++) begin
            drive_bit(stream_q[i], 1'b1);
            if (i == 16) begin
                checks++;
                if (data_valid !== 1'b1 || overrun !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_first_word got dv=%b ov=%b required dv=1 ov=0", data_valid, overrun);
                end
            end
            if (i == 24) begin
                checks++;
                if (overrun !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_overrun got=%b required=1", overrun);
                end
            end
        end
        idle(4);
        checks++;
        if (data_out !== exp_q[0] || data_valid !== 1'b1 || got_q.size() !== 0) begin
            errors++;
            $display("FAIL bp_hold got do=%h dv=%b taken=%0d required do=%h dv=1 taken=0",
                     data_out, data_valid, got_q.size(), exp_q[0]);
        end
        checks++;
        if (fd_cnt !== 1 || overrun !== 1'b1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL bp_frame got fd=%0d ov=%b lk=%b required fd=1 ov=1 lk=0", fd_cnt, overrun, locked);
        end
        data_ready = 1'b1;
        idle(2);
        checks++;
        if (overrun !== 1'b1 || data_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_sticky got ov=%b dv=%b required ov=1 dv=0", overrun, data_valid);
        end
    endtask

    task automatic test_sparse_valid();
        logic [7:0] gv;
        $display("test_sparse_valid");
        do_reset();
        data_ready = 1'b1;
        stream_q.delete();
        push_byte(8'hD5); push_byte(8'h3C); push_byte(8'hA5); push_byte(8'h00); push_byte(8'hFF);
        model_stream();
        send_stream(2);
        checks++;
        if (got_q.size() !== exp_q.size() || fd_cnt !== 1) begin
            errors++;
            $display("FAIL sparse_count got=%0d fd=%0d required=%0d fd=1", got_q.size(), fd_cnt, exp_q.size());
        end
        foreach (exp_q[k]) begin
            gv = (k < got_q.size()) ? got_q[k] : 8'hxx;
            checks++;
            if (gv !== exp_q[k]) begin
                errors++;
                $display("FAIL sparse_word%0d got=%h required=%h", k, gv, exp_q[k]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] gv;
        $display("test_reset_midframe");
        do_reset();
        data_ready = 1'b1;
        stream_q.delete();
        push_byte(8'hD5);
        for (int i = 0; i < 3; i++) stream_q.push_back(1'($urandom));
        foreach (stream_q[i]) drive_bit(stream_q[i], 1'b1);
        idle(1);
        checks++;
        if (got_q.size() !== 0 || data_valid !== 1'b0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre got taken=%0d dv=%b lk=%b required taken=0 dv=0 lk=1",
                     got_q.size(), data_valid, locked);
        end
        do_reset();
        checks++;
        if (data_valid !== 1'b0 || frame_done !== 1'b0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL midrst_post got dv=%b fd=%b lk=%b required all 0", data_valid, frame_done, locked);
        end
        stream_q.delete();
        push_byte(8'hD5); push_byte(8'h3C); push_byte(8'hA5); push_byte(8'h00); push_byte(8'hFF);
        model_stream();
        send_stream(0);
        checks++;
        if (got_q.size() !== exp_q.size() || fd_cnt !== 1) begin
            errors++;
            $display("FAIL midrst_count got=%0d fd=%0d required=%0d fd=1", got_q.size(), fd_cnt, exp_q.size());
        end
        foreach (exp_q[k]) begin
            gv = (k < got_q.size()) ? got_q[k] : 8'hxx;
            checks++;
            if (gv !== exp_q[k]) begin
                errors++;
                $display("FAIL midrst_word%0d got=%h required=%h", k, gv, exp_q[k]);
            end
        end
    endtask

    task automatic test_random_frames();
        logic [7:0] gv;
        int         noise;
        $display("test_random_frames");
        do_reset();
        data_ready = 1'b1;
        stream_q.delete();
        for (int f = 0; f < 4; f++) begin
            noise = int'($urandom_range(0, 12));
            for (int i = 0; i < noise; i++) stream_q.push_back(1'($urandom));
            push_byte(8'hD5);
            for (int i = 0; i < 4; i++) push_byte(8'($urandom));
        end
        model_stream();
        send_stream(-1);
        checks++;
        if (got_q.size() !== exp_q.size() || fd_cnt !== exp_frames) begin
            errors++;
            $display("FAIL random_count got=%0d fd=%0d required=%0d fd=%0d",
                     got_q.size(), fd_cnt, exp_q.size(), exp_frames);
        end
        foreach (exp_q[k]) begin
            gv = (k < got_q.size()) ? got_q[k] : 8'hxx;
            checks++;
            if (gv !== exp_q[k]) begin
                errors++;
                $display("FAIL random_word%0d got=%h required=%h", k, gv, exp_q[k]);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        srl_in     = 1'b0;
        srl_valid  = 1'b0;
        data_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_basic();
        test_false_sync();
        test_backpressure();
        test_sparse_valid();
        test_reset_midframe();
        test_random_frames();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
